// File: rtl/hazard_sequencer_if.sv
// Control bundle between the pipeline stages and the hazard sequencer.
// The stage side drives the status inputs; the sequencer drives flush, stall and redirect.
interface hazard_sequencer_if #(
    parameter int REG_ADDR_W = 3,
    parameter int PC_WORDS   = 2
);
    localparam int IDX_W = (PC_WORDS > 1) ? $clog2(PC_WORDS) : 1;

    logic                  i_interrupt;
    logic                  i_branch_decision;
    logic                  i_push_pc;
    logic                  i_pop_pc;
    logic                  i_mem_read_exm;
    logic                  i_write_back_exm;
    logic [REG_ADDR_W-1:0] i_rd_exm;
    logic [REG_ADDR_W-1:0] i_rs_dec;
    logic [REG_ADDR_W-1:0] i_rt_dec;
    logic                  i_uses_rs_dec;
    logic                  i_uses_rt_dec;
    logic                  o_flush_f_d;
    logic                  o_flush_d_em;
    logic                  o_stall_f;
    logic                  o_stall_d_em;
    logic                  o_branch_decision;
    logic                  o_int_active;
    logic [IDX_W-1:0]      o_stack_word_idx;

    modport master (
        output i_interrupt, i_branch_decision, i_push_pc, i_pop_pc,
               i_mem_read_exm, i_write_back_exm, i_rd_exm, i_rs_dec, i_rt_dec,
               i_uses_rs_dec, i_uses_rt_dec,
        input  o_flush_f_d, o_flush_d_em, o_stall_f, o_stall_d_em,
               o_branch_decision, o_int_active, o_stack_word_idx
    );

    modport slave (
        input  i_interrupt, i_branch_decision, i_push_pc, i_pop_pc,
               i_mem_read_exm, i_write_back_exm, i_rd_exm, i_rs_dec, i_rt_dec,
               i_uses_rs_dec, i_uses_rt_dec,
        output o_flush_f_d, o_flush_d_em, o_stall_f, o_stall_d_em,
               o_branch_decision, o_int_active, o_stack_word_idx
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Central pipeline control: branch flushes, multi-word PC push/pop, load-use stalls
// and interrupt entry (drain, push return PC, redirect to vector).
module hazard_sequencer #(
    parameter int REG_ADDR_W   = 3,
    parameter int PC_WORDS     = 2,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    hazard_sequencer_if.slave bus
);
    localparam int IDX_W   = (PC_WORDS > 1) ? $clog2(PC_WORDS) : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [IDX_W-1:0]   LAST_WORD  = IDX_W'(PC_WORDS - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam bit SINGLE_WORD = (PC_WORDS == 1);

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP,
        INT_DRAIN,
        INT_PUSH
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   word_q, word_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               pending_q, pending_d;

    logic               load_use;
    logic               flush_f_d_c, flush_d_em_c, stall_f_c, stall_d_em_c;
    logic               branch_c, int_active_c;
    logic [IDX_W-1:0]   idx_c;

    assign load_use = bus.i_mem_read_exm & bus.i_write_back_exm &
                      ((bus.i_uses_rs_dec & (bus.i_rs_dec == bus.i_rd_exm)) |
                       (bus.i_uses_rt_dec & (bus.i_rt_dec == bus.i_rd_exm)));

    // The IDLE cycle that sees CALL/RET already acts as stack word 0, so the
    // PUSH/POP states only ever hold words 1..PC_WORDS-1.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        drain_d      = drain_q;
        pending_d    = pending_q | bus.i_interrupt;
        flush_f_d_c  = 1'b0;
        flush_d_em_c = 1'b0;
        stall_f_c    = 1'b0;
        stall_d_em_c = 1'b0;
        branch_c     = 1'b0;
        int_active_c = 1'b0;
        idx_c        = word_q;

        case (state_q)
            IDLE: begin
                idx_c = '0;
                if (bus.i_push_pc || bus.i_pop_pc) begin
                    if (SINGLE_WORD) begin
                        branch_c     = 1'b1;
                        flush_f_d_c  = 1'b1;
                        flush_d_em_c = 1'b1;
                    end else begin
                        stall_f_c    = 1'b1;
                        stall_d_em_c = 1'b1;
                        state_d      = bus.i_push_pc ? PUSH : POP;
                        word_d       = IDX_W'(1);
                    end
                end else if (bus.i_branch_decision) begin
                    branch_c     = 1'b1;
                    flush_f_d_c  = 1'b1;
                    flush_d_em_c = 1'b1;
                end else if (load_use) begin
                    stall_f_c    = 1'b1;
                    flush_d_em_c = 1'b1;
                end else if (pending_q) begin
                    state_d   = INT_DRAIN;
                    drain_d   = '0;
                    pending_d = bus.i_interrupt;
                end
            end

            PUSH, POP, INT_PUSH: begin
                int_active_c = (state_q == INT_PUSH);
                if (word_q == LAST_WORD) begin
                    branch_c     = 1'b1;
                    flush_f_d_c  = 1'b1;
                    flush_d_em_c = 1'b1;
                    state_d      = IDLE;
                    word_d       = '0;
                end else begin
                    stall_f_c    = 1'b1;
                    stall_d_em_c = 1'b1;
                    word_d       = word_q + IDX_W'(1);
                end
            end

            INT_DRAIN: begin
                int_active_c = 1'b1;
                stall_f_c    = 1'b1;
                flush_f_d_c  = 1'b1;
                if (drain_q == LAST_DRAIN) begin
                    state_d = INT_PUSH;
                    word_d  = '0;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                word_d  = '0;
                drain_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            word_q    <= '0;
            drain_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            drain_q   <= drain_d;
            pending_q <= pending_d;
        end
    end

    // Outputs are forced low while reset is held, even if the stages still assert inputs.
    assign bus.o_flush_f_d       = flush_f_d_c  & ~i_reset;
    assign bus.o_flush_d_em      = flush_d_em_c & ~i_reset;
    assign bus.o_stall_f         = stall_f_c    & ~i_reset;
    assign bus.o_stall_d_em      = stall_d_em_c & ~i_reset;
    assign bus.o_branch_decision = branch_c     & ~i_reset;
    assign bus.o_int_active      = int_active_c & ~i_reset;
    assign bus.o_stack_word_idx  = i_reset ? '0 : idx_c;
endmodule
